// File: rtl/aes_stage_arbiter.sv
// rtl/aes_stage_arbiter.sv - two-requester round-robin arbiter in front of a shared AES stage
module aes_stage_arbiter #(
    parameter int DATA_W         = 64,
    parameter int IN_BEATS       = 2,
    parameter int OUT_BEATS_NORM = 2,
    parameter int OUT_BEATS_BYP  = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*DATA_W-1:0]   req_data,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  core_in_valid,
    input  logic                  core_in_ready,
    output logic [DATA_W-1:0]     core_in_data,
    input  logic                  core_out_valid,
    output logic                  core_out_ready,
    input  logic [DATA_W-1:0]     core_out_data,
    input  logic [2:0]            bypass_control,
    output logic                  busy,
    output logic                  owner,
    output logic [15:0]           job_cnt0,
    output logic [15:0]           job_cnt1
);

    localparam int OUT_MAX   = (OUT_BEATS_BYP > OUT_BEATS_NORM) ? OUT_BEATS_BYP : OUT_BEATS_NORM;
    localparam int MAX_BEATS = (OUT_MAX > IN_BEATS) ? OUT_MAX : IN_BEATS;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              owner_d;
    logic              rr_ptr_q;
    logic              rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  len_d;
    logic              inc0;
    logic              inc1;
    logic [DATA_W-1:0] lane_data;
    logic              unused_bypass;

    // Only bit 0 of bypass_control has a meaning today.
    assign unused_bypass = ^bypass_control[2:1];

    assign lane_data = owner ? req_data[2*DATA_W-1 -: DATA_W] : req_data[DATA_W-1:0];

    // Busy is forced low while reset is asserted so the reset cycle itself looks idle.
    assign busy = rst_n && (state_q != S_IDLE);

    // State, grant, beat counter, response length and per-requester job counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            owner    <= 1'b0;
            rr_ptr_q <= 1'b0;
            cnt_q    <= '0;
            len_q    <= CNT_W'(OUT_BEATS_NORM);
            job_cnt0 <= 16'd0;
            job_cnt1 <= 16'd0;
        end else begin
            state_q  <= state_d;
            owner    <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            if (inc0) begin
                job_cnt0 <= job_cnt0 + 16'd1;
            end
            if (inc1) begin
                job_cnt1 <= job_cnt1 + 16'd1;
            end
        end
    end

    // Next-state logic and the zero-latency steering of both datapaths.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner;
        rr_ptr_d       = rr_ptr_q;
        cnt_d          = cnt_q;
        len_d          = len_q;
        inc0           = 1'b0;
        inc1           = 1'b0;
        req_ready      = 2'b00;
        core_in_valid  = 1'b0;
        core_in_data   = '0;
        rsp_valid      = 2'b00;
        rsp_data       = '0;
        core_out_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Grant only; no beat moves in this cycle. Length is latched here
                // so later bypass changes cannot reshape the running job.
                if (|req_valid) begin
                    owner_d = req_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
                    len_d   = bypass_control[0] ? CNT_W'(OUT_BEATS_BYP) : CNT_W'(OUT_BEATS_NORM);
                    cnt_d   = '0;
                    state_d = S_FWD;
                end
            end
            S_FWD: begin
                core_in_valid    = req_valid[owner];
                core_in_data     = lane_data;
                req_ready[owner] = core_in_ready;
                if (req_valid[owner] && core_in_ready) begin
                    if (cnt_q == CNT_W'(IN_BEATS - 1)) begin
                        cnt_d   = '0;
                        state_d = S_RSP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_RSP: begin
                rsp_valid[owner] = core_out_valid;
                rsp_data         = core_out_valid ? core_out_data : '0;
                core_out_ready   = rsp_ready[owner];
                if (core_out_valid && rsp_ready[owner]) begin
                    if (cnt_q == len_q - CNT_W'(1)) begin
                        cnt_d    = '0;
                        inc0     = ~owner;
                        inc1     = owner;
                        rr_ptr_d = ~owner;
                        state_d  = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // No handshake may complete while reset is asserted, whatever the old state.
        if (!rst_n) begin
            req_ready      = 2'b00;
            core_in_valid  = 1'b0;
            rsp_valid      = 2'b00;
            rsp_data       = '0;
            core_out_ready = 1'b0;
        end
    end

endmodule

// File: doc/aes_stage_arbiter.md
AES_STAGE_ARBITER -- requirements
Module: aes_stage_arbiter

Interface
- REQ-001 The block SHALL use one clock and a synchronous, active-low reset, with ports named clk and rst_n.
- REQ-002 Parameter DATA_W, 64: beat width on all streams.
- REQ-003 Parameter IN_BEATS, 2: request beats per job (one 128-bit block, upper half first).
- REQ-004 Parameter OUT_BEATS_NORM, 2: response beats per job when bypass is off.
- REQ-005 Parameter OUT_BEATS_BYP, 18: response beats per job when bypass is on (result plus 8 keys).
- REQ-006 Ports (name, direction, width, meaning):
  - clk, in, 1: clock.
  - rst_n, in, 1: synchronous active-low reset.
  - req_valid, in, 2: requester i has a request beat.
  - req_ready, out, 2: request beat accepted from requester i.
  - req_data, in, 2xDATA_W: request beat data, one lane per requester.
  - rsp_valid, out, 2: response beat valid to requester i.
  - rsp_ready, in, 2: requester i accepts the response beat.
  - rsp_data, out, DATA_W: response beat data, shared by both requesters.
  - core_in_valid, out, 1: beat offered to the shared AES stage.
  - core_in_ready, in, 1: the stage accepts the beat.
  - core_in_data, out, DATA_W: beat data to the stage.
  - core_out_valid, in, 1: the stage has a result beat.
  - core_out_ready, out, 1: the block accepts the result beat.
  - core_out_data, in, DATA_W: result beat data.
  - bypass_control, in, 3: bit 0 selects key-forwarding output length.
  - busy, out, 1: a job is in progress.
  - owner, out, 1: index of the granted requester.
  - job_cnt0, out, 16: count of completed jobs for requester 0.
  - job_cnt1, out, 16: count of completed jobs for requester 1.

Function
- REQ-007 The FSM SHALL have three states: S_IDLE, S_FWD and S_RSP.
- REQ-008 In S_IDLE, if any req_valid bit is high, the block SHALL grant one requester, register owner and the beat count, then enter S_FWD on the next cycle; no beat transfers in S_IDLE.
- REQ-009 Arbitration SHALL be round-robin:
  - rr_ptr marks the preferred requester.
  - If both requesters are valid, rr_ptr wins.
  - If only one is valid, it wins.
- REQ-010 After each completed job, rr_ptr SHALL be set to the requester that did not own that job.
- REQ-011 The response length SHALL be fixed at grant: OUT_BEATS_BYP if bypass_control[0]=1, else OUT_BEATS_NORM; a later bypass change SHALL NOT affect the job in progress.
- REQ-012 In S_FWD, the datapath SHALL be combinational with zero latency:
  - core_in_valid = req_valid[owner].
  - core_in_data = req_data[owner].
  - req_ready[owner] = core_in_ready.
  - All other req_ready bits low.
- REQ-013 A beat counter SHALL increment on each core_in handshake; on handshake number IN_BEATS, the block SHALL clear the counter and enter S_RSP.
- REQ-014 In S_RSP, the datapath SHALL be combinational:
  - rsp_valid[owner] = core_out_valid.
  - rsp_data = core_out_data.
  - core_out_ready = rsp_ready[owner].
  - The non-owner rsp_valid bit is low.
- REQ-015 In S_RSP, the counter SHALL count response handshakes; on the final beat, the block SHALL increment the owner's job_cnt (wrapping at 16 bits), update rr_ptr and return to S_IDLE.
- REQ-016 Outside S_FWD, core_in_valid SHALL be low; outside S_RSP, core_out_ready and all rsp_valid bits SHALL be low.
- REQ-017 Outside S_IDLE and S_FWD, every req_ready bit SHALL be 0.
- REQ-018 rsp_data SHALL be 0 whenever no rsp_valid bit is high.
- REQ-019 busy SHALL be 1 in S_FWD and S_RSP, and 0 in S_IDLE.
- REQ-020 owner SHALL hold its value from grant until the next grant.
- REQ-021 The block SHALL NOT preempt a job: the non-owner's req_valid is ignored until the block returns to S_IDLE.
- REQ-022 If a requester drops req_valid mid-job, the block SHALL stall in S_FWD indefinitely; there is no timeout.
- REQ-023 Back-pressure from rsp_ready SHALL stall the stage and drop no beats.
- REQ-024 A core_out_valid that arrives while in S_FWD SHALL NOT be accepted (core_out_ready is 0).
- REQ-025 Back-to-back jobs SHALL have exactly one S_IDLE cycle between the final response beat and the next grant.

Reset
- REQ-026 When rst_n=0 at a clock edge, the block SHALL enter S_IDLE and clear:
  - the beat counter, rr_ptr (set to 0) and owner (set to 0);
  - job_cnt0 and job_cnt1 (set to 0);
  - the registered response length (set to OUT_BEATS_NORM).
- REQ-027 During reset and on the cycle after it, all valid and ready outputs, and busy, SHALL be 0.
- REQ-028 A reset during S_FWD or S_RSP SHALL abort the job with no job_cnt increment; the stage is assumed to be reset by the same rst_n.

Verification
- REQ-029 Single job: req0 sends 0xAAAA_0000_0000_0001 then 0x0000_0000_0000_0002 with bypass=0; the core returns 2 beats. Required: both beats appear on core_in in order, rsp_valid[0] is high for exactly 2 beats, job_cnt0=1, rr_ptr=1.
- REQ-030 Contention: req0 and req1 are both valid continuously from reset for 4 jobs. Required: owner sequence 0,1,0,1, and job_cnt0=job_cnt1=2.
- REQ-031 Bypass: bypass_control[0]=1 at grant and is cleared during S_FWD. Required: 18 response beats pass before S_IDLE.
- REQ-032 Back-pressure: rsp_ready is toggled 1,0,0,1 during S_RSP. Required: core_out_ready mirrors rsp_ready, rsp_data is unchanged while stalled, no beat is lost or duplicated.
- REQ-033 Reset mid-job: rst_n is pulsed low after the first request beat. Required: next cycle state is S_IDLE, busy=0, job_cnt0=0, req_ready=0.
- REQ-034 Counter wrap: job_cnt1 is preloaded by running 65535 jobs, then one more job is run. Required: job_cnt1=0.
